d_module_code_check: RTL and testbench



---
 rtl/d_lock_pkg.sv | 23 ++
 rtl/d_module_code_check.sv | 179 +++++++++++++++++
 tb/tb_d_module_code_check.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/d_lock_pkg.sv
// Shared types and defaults for the keypad lock slice.
package d_lock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_NEWCODE,
    ST_STOP
  } lock_state_t;

  localparam int unsigned CODE_LEN_DFLT    = 4;
  localparam logic [15:0] DEFAULT_CODE_DFLT = 16'h1234;
  localparam int unsigned LOCK_THRESH_DFLT = 3;
  localparam int unsigned ERR_MAX          = 7;

  // Saturating increment of the wrong-entry counter.
  function automatic logic [2:0] err_inc(input logic [2:0] e);
    return (e == 3'(ERR_MAX)) ? e : e + 3'd1;
  endfunction

endpackage

// File: rtl/d_module_code_check.sv
// Keypad code entry and verification feeding d_module_timer.
module d_module_code_check
  import d_lock_pkg::*;
#(
  parameter int unsigned CODE_LEN = CODE_LEN_DFLT,
  parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE = (CODE_LEN*4)'(DEFAULT_CODE_DFLT),
  parameter int unsigned LOCK_THRESH = LOCK_THRESH_DFLT
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic       btn_set,
  input  logic       enb_set,
  input  logic       tmr_done,
  output logic       enb_lock,
  output logic       gen_stop,
  output logic [2:0] error_counter,
  output logic [2:0] entry_cnt,
  output logic       code_changed
);

  localparam int unsigned CW  = CODE_LEN * 4;
  localparam logic [3:0]  LEN = 4'(CODE_LEN);

  // Registered copies of the inputs; the FSM acts one cycle after sampling,
  // giving enter -> CHECK -> result on the following two edges.
  logic       kv_q, ent_q, clr_q, set_q, es_q, done_q;
  logic [3:0] kd_q;

  lock_state_t    state, state_n;
  logic [CW-1:0]  entry, entry_n, stored, stored_n;
  logic [3:0]     cnt, cnt_n;
  logic [2:0]     err, err_n;
  logic           lock, lock_n, stop, stop_n, chg, chg_n;
  logic           digit_ok;
  logic [CW-1:0]  entry_shift;

  assign digit_ok    = kv_q && (kd_q <= 4'd9);
  assign entry_shift = CW'({entry, kd_q});

  // Input sampling stage.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      kv_q   <= 1'b0;
      kd_q   <= '0;
      ent_q  <= 1'b0;
      clr_q  <= 1'b0;
      set_q  <= 1'b0;
      es_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      kv_q   <= key_valid;
      kd_q   <= key_digit;
      ent_q  <= btn_enter;
      clr_q  <= btn_clear;
      set_q  <= btn_set;
      es_q   <= enb_set;
      done_q <= tmr_done;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state  <= ST_LOCKED;
      entry  <= '0;
      cnt    <= '0;
      stored <= DEFAULT_CODE;
      err    <= '0;
      lock   <= 1'b0;
      stop   <= 1'b0;
      chg    <= 1'b0;
    end else begin
      state  <= state_n;
      entry  <= entry_n;
      cnt    <= cnt_n;
      stored <= stored_n;
      err    <= err_n;
      lock   <= lock_n;
      stop   <= stop_n;
      chg    <= chg_n;
    end
  end

  // Next-state and next-data logic; clear > enter > digit within a cycle.
  always_comb begin
    state_n  = state;
    entry_n  = entry;
    cnt_n    = cnt;
    stored_n = stored;
    err_n    = err;
    lock_n   = lock;
    stop_n   = stop;
    chg_n    = 1'b0;
    unique case (state)
      ST_LOCKED, ST_ENTRY: begin
        if (done_q || clr_q) begin
          entry_n = '0;
          cnt_n   = '0;
          state_n = ST_LOCKED;
        end else if (ent_q) begin
          state_n = ST_CHECK;
        end else if (digit_ok && (cnt < LEN)) begin
          entry_n = entry_shift;
          cnt_n   = cnt + 4'd1;
          state_n = ST_ENTRY;
        end
      end
      ST_CHECK: begin
        entry_n = '0;
        cnt_n   = '0;
        if ((cnt == LEN) && (entry == stored)) begin
          err_n   = '0;
          lock_n  = 1'b1;
          state_n = ST_OPEN;
        end else begin
          err_n = err_inc(err);
          if (32'(err_inc(err)) >= LOCK_THRESH) begin
            stop_n  = 1'b1;
            state_n = ST_STOP;
          end else begin
            state_n = ST_LOCKED;
          end
        end
      end
      ST_OPEN: begin
        if (done_q) begin
          lock_n  = 1'b0;
          state_n = ST_LOCKED;
        end else if (set_q && es_q) begin
          entry_n = '0;
          cnt_n   = '0;
          state_n = ST_NEWCODE;
        end
      end
      ST_NEWCODE: begin
        if (done_q) begin
          entry_n = '0;
          cnt_n   = '0;
          lock_n  = 1'b0;
          state_n = ST_LOCKED;
        end else if (!es_q || clr_q) begin
          entry_n = '0;
          cnt_n   = '0;
          state_n = ST_OPEN;
        end else if (ent_q) begin
          if (cnt == LEN) begin
            stored_n = entry;
            chg_n    = 1'b1;
          end
          entry_n = '0;
          cnt_n   = '0;
          state_n = ST_OPEN;
        end else if (digit_ok && (cnt < LEN)) begin
          entry_n = entry_shift;
          cnt_n   = cnt + 4'd1;
        end
      end
      ST_STOP: begin
        if (done_q) begin
          stop_n  = 1'b0;
          state_n = ST_LOCKED;
        end
      end
      default: state_n = ST_LOCKED;
    endcase
  end

  assign enb_lock      = lock;
  assign gen_stop      = stop;
  assign error_counter = err;
  // Display count is 3 bits wide; an 8-digit entry shows as 0 when full.
  assign entry_cnt     = cnt[2:0];
  assign code_changed  = chg;

endmodule

// File: tb/tb_d_module_code_check.sv
// Scoreboard bench for d_module_code_check.
module tb_d_module_code_check;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = '0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_set = 1'b0;
  logic       enb_set = 1'b0;
  logic       tmr_done = 1'b0;
  logic       enb_lock, gen_stop, code_changed;
  logic [2:0] error_counter, entry_cnt;

  typedef struct {
    logic       lock;
    logic       stop;
    logic [2:0] err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] m_code;
  logic [15:0] m_ent;
  int          m_cnt;
  int          m_err;

  d_module_code_check dut (
    .clk_in(clk_in), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
    .btn_enter(btn_enter), .btn_clear(btn_clear), .btn_set(btn_set),
    .enb_set(enb_set), .tmr_done(tmr_done), .enb_lock(enb_lock),
    .gen_stop(gen_stop), .error_counter(error_counter), .entry_cnt(entry_cnt),
    .code_changed(code_changed)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    m_code = 16'h1234;
    m_ent = '0;
    m_cnt = 0;
    m_err = 0;
    sb.delete();
    check_val("rst_lock", 32'(enb_lock), 0);
    check_val("rst_stop", 32'(gen_stop), 0);
    check_val("rst_err", 32'(error_counter), 0);
    check_val("rst_cnt", 32'(entry_cnt), 0);
    check_val("rst_chg", 32'(code_changed), 0);
  endtask

  task automatic press_seq(input logic [31:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key_digit = code[(n-1-i)*4 +: 4];
      tick(1);
      key_valid = 1'b0;
    end
  endtask

  // Types digits and mirrors them into the reference entry buffer.
  task automatic type_digits(input logic [31:0] code, input int n);
    press_seq(code, n);
    for (int i = 0; i < n; i++) begin
      if (m_cnt < 4) begin
        m_ent = {m_ent[11:0], code[(n-1-i)*4 +: 4]};
        m_cnt++;
      end
    end
  endtask

  task automatic pulse_done();
    tmr_done = 1'b1;
    tick(1);
    tmr_done = 1'b0;
    tick(2);
  endtask

  // Presses enter, predicts the verdict, then compares once the result lands.
  task automatic submit(input string tag);
    exp_t e;
    exp_t g;
    if (m_cnt == 4 && m_ent == m_code) begin
      m_err = 0;
      e.lock = 1'b1;
      e.stop = 1'b0;
    end else begin
      m_err = (m_err < 7) ? m_err + 1 : 7;
      e.lock = 1'b0;
      e.stop = (m_err >= 3);
    end
    e.err = 3'(m_err);
    sb.push_back(e);
    m_ent = '0;
    m_cnt = 0;
    btn_enter = 1'b1;
    tick(1);
    btn_enter = 1'b0;
    tick(1);
    check_val({tag, "_early_lock"}, 32'(enb_lock), 0);
    check_val({tag, "_early_stop"}, 32'(gen_stop), 0);
    tick(1);
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 1, 0);
    end else begin
      g = sb.pop_front();
      check_val({tag, "_lock"}, 32'(enb_lock), 32'(g.lock));
      check_val({tag, "_stop"}, 32'(gen_stop), 32'(g.stop));
      check_val({tag, "_err"}, 32'(error_counter), 32'(g.err));
      check_val({tag, "_cnt"}, 32'(entry_cnt), 0);
    end
  endtask

  initial begin
    // Correct code unlocks, session end relocks.
    do_reset();
    type_digits(32'h1234, 4);
    tick(2);
    check_val("t1_cnt4", 32'(entry_cnt), 4);
    submit("t1");
    pulse_done();
    check_val("t1_relock", 32'(enb_lock), 0);

    // Three wrong entries lock out; keys ignored in STOP.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      type_digits(32'h1235, 4);
      submit("t2");
    end
    press_seq(32'h1234, 4);
    btn_enter = 1'b1;
    tick(1);
    btn_enter = 1'b0;
    tick(3);
    check_val("t2_stop_hold", 32'(gen_stop), 1);
    check_val("t2_stop_nolock", 32'(enb_lock), 0);
    check_val("t2_stop_cnt", 32'(entry_cnt), 0);
    pulse_done();
    check_val("t2_unstop", 32'(gen_stop), 0);
    check_val("t2_err_keep", 32'(error_counter), 3);

    // Short entry is wrong; excess digits ignored.
    do_reset();
    type_digits(32'h123, 3);
    submit("t3a");
    type_digits(32'h12345, 5);
    tick(2);
    check_val("t3_cnt_sat", 32'(entry_cnt), 4);
    submit("t3b");
    pulse_done();

    // Clear beats a same-cycle digit.
    do_reset();
    type_digits(32'h12, 2);
    tick(2);
    check_val("t4_cnt2", 32'(entry_cnt), 2);
    btn_clear = 1'b1;
    key_valid = 1'b1;
    key_digit = 4'd3;
    tick(1);
    btn_clear = 1'b0;
    key_valid = 1'b0;
    m_ent = '0;
    m_cnt = 0;
    tick(2);
    check_val("t4_cleared", 32'(entry_cnt), 0);
    type_digits(32'h1234, 4);
    submit("t4");
    pulse_done();

    // Code change while open, then the new code is the only one accepted.
    do_reset();
    type_digits(32'h1234, 4);
    submit("t5a");
    enb_set = 1'b1;
    btn_set = 1'b1;
    tick(1);
    btn_set = 1'b0;
    tick(2);
    press_seq(32'h9876, 4);
    tick(2);
    check_val("t5_new_cnt", 32'(entry_cnt), 4);
    btn_enter = 1'b1;
    tick(1);
    btn_enter = 1'b0;
    tick(1);
    check_val("t5_chg_hi", 32'(code_changed), 1);
    tick(1);
    check_val("t5_chg_lo", 32'(code_changed), 0);
    check_val("t5_still_open", 32'(enb_lock), 1);
    m_code = 16'h9876;
    enb_set = 1'b0;
    pulse_done();
    check_val("t5_relock", 32'(enb_lock), 0);
    type_digits(32'h1234, 4);
    submit("t5b");
    type_digits(32'h9876, 4);
    submit("t5c");
    pulse_done();

    // Saturation at 7 across repeated lockouts.
    for (int i = 0; i < 8; i++) begin
      type_digits(32'h1235, 4);
      submit("t6");
      if (m_err >= 3 && i < 7) begin
        pulse_done();
        check_val("t6_unstop", 32'(gen_stop), 0);
        check_val("t6_err_keep", 32'(error_counter), 32'(m_err));
      end
    end
    check_val("t6_err_sat", 32'(error_counter), 7);
    check_val("t6_in_stop", 32'(gen_stop), 1);

    // Reset in STOP restores everything including the default code.
    do_reset();
    type_digits(32'h1234, 4);
    submit("t6_default");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
